// File: rtl/lower_tri_packer.sv
// Lower-triangular packer: frames the extractor's kept-element stream as AXI-Stream with tlast per matrix.
// Optional LOWER_TRI_PACK_ROWLAST_EN adds out_trow_last, marking the final element of each row.
module lower_tri_packer #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  out_tlast
`ifdef LOWER_TRI_PACK_ROWLAST_EN
    ,
    output logic                  out_trow_last
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int POS_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    typedef struct packed {
`ifdef LOWER_TRI_PACK_ROWLAST_EN
        logic                  row_last;
`endif
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [POS_W-1:0] row_q,    row_d;
    logic [POS_W-1:0] col_q,    col_d;

    logic   push;
    logic   pop;
    entry_t wr_entry;
    entry_t head;

    // No pass-through when full: a same-cycle pop does not reopen the input.
    assign in_tready  = !rst && (count_q != CNT_FULL);
    assign out_tvalid = (count_q != '0);
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tvalid && out_tready;

    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        row_d    = row_q;
        col_d    = col_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (col_q == row_q) begin
                col_d = '0;
                row_d = (row_q == POS_LAST) ? '0 : row_q + POS_ONE;
            end else begin
                col_d = col_q + POS_ONE;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Framing flags use the position before this push advances it.
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = in_tdata;
        wr_entry.last = (row_q == POS_LAST) && (col_q == POS_LAST);
`ifdef LOWER_TRI_PACK_ROWLAST_EN
        wr_entry.row_last = (col_q == row_q);
`endif
    end

    always_comb begin
        head = out_tvalid ? mem_q[rd_ptr_q] : '0;
    end

    assign out_tdata = head.data;
    assign out_tlast = head.last;
`ifdef LOWER_TRI_PACK_ROWLAST_EN
    assign out_trow_last = head.row_last;
`endif

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

    // NOTE: storage is not reset; count_q gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_lower_tri_packer.sv
// Directed bench for lower_tri_packer (SIZE=4, FIFO_DEPTH=4); queue scoreboard supplies expected outputs.
// Also checks out_trow_last when built with LOWER_TRI_PACK_ROWLAST_EN.
module tb_lower_tri_packer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int N     = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_tdata;
    logic          in_tvalid;
    logic          in_tready;
    logic [DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic          out_tlast;
`ifdef LOWER_TRI_PACK_ROWLAST_EN
    logic          out_trow_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected entries {row_last, last, data}; idx is the position within the current matrix.
    logic [DW+1:0] exp_q[$];
    int            idx = 0;

    lower_tri_packer #(.SIZE(4), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast)
`ifdef LOWER_TRI_PACK_ROWLAST_EN
        ,
        .out_trow_last (out_trow_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the scoreboard, take the edge, update the scoreboard.
    task automatic cycle(input logic v, input logic [31:0] d, input logic rdy);
        logic          exp_ready;
        logic          exp_valid;
        logic          do_push;
        logic          do_pop;
        logic [DW+1:0] head;
        in_tvalid  = v;
        in_tdata   = d;
        out_tready = rdy;
        #1;
        exp_ready = !rst && (exp_q.size() != DEPTH);
        exp_valid = (exp_q.size() != 0);
        head      = exp_valid ? exp_q[0] : '0;
        check("in_tready",  in_tready,  exp_ready);
        check("out_tvalid", out_tvalid, exp_valid);
        check("out_tdata",  out_tdata,  head[DW-1:0]);
        check("out_tlast",  out_tlast,  head[DW]);
`ifdef LOWER_TRI_PACK_ROWLAST_EN
        check("out_trow_last", out_trow_last, head[DW+1]);
`endif
        do_push = v && exp_ready;
        do_pop  = exp_valid && rdy;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            idx = 0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back({(idx == 0 || idx == 2 || idx == 5 || idx == 9), (idx == N - 1), d});
                idx = (idx + 1) % N;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 1; k++) begin
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b0);
        check("rst_in_tready", in_tready, 1'b0);
        check("rst_out_tvalid", out_tvalid, 1'b0);
        check("rst_out_tdata", out_tdata, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_tready", in_tready, 1'b1);

        // One matrix, streaming through with the consumer always ready.
        for (int i = 1; i <= N; i++) cycle(1'b1, i, 1'b1);
        drain();

        // Two matrices back to back: tlast on the 10th and 20th elements.
        for (int i = 1; i <= 2 * N; i++) cycle(1'b1, 32'h200 + i, 1'b1);
        drain();

        // Backpressure: fill to full, hold element 5 while refused, then release.
        for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b0);
        check("full_in_tready", in_tready, 1'b0);
        cycle(1'b1, 5, 1'b0);
        cycle(1'b1, 5, 1'b0);
        check("full_hold_data", out_tdata, 32'd1);
        cycle(1'b1, 5, 1'b1);
        check("ready_after_pop", in_tready, 1'b1);
        cycle(1'b1, 5, 1'b1);
        cycle(1'b1, 6, 1'b1);
        drain();

        // Reset mid-matrix discards buffered entries and restarts framing.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'h40 + i, 1'b0);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0);
        check("midrst_out_tvalid", out_tvalid, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= N; i++) cycle(1'b1, 32'h100 + i, 1'b1);
        drain();

        // Simultaneous push and pop at count 2.
        cycle(1'b1, 32'hA0, 1'b0);
        cycle(1'b1, 32'hA1, 1'b0);
        cycle(1'b1, 32'hA2, 1'b1);
        check("pp_out_tdata", out_tdata, 32'hA1);
        check("pp_out_tvalid", out_tvalid, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lower_tri_packer.md
# lower_tri_packer

Downstream stage of the lower-triangular extractor. Consumes the stream of kept elements (row-major, i ≥ j only, SIZE·(SIZE+1)/2 per matrix) and re-frames it as a packed AXI-Stream with `out_tlast` marking the final element of each matrix. A small FIFO decouples the extractor from backpressure further down the matrix pipeline.

## Interface
- `SIZE`, 4: matrix dimension; elements per matrix N = SIZE·(SIZE+1)/2 (10 at default).
- `DATA_WIDTH`, 32: element width.
- `FIFO_DEPTH`, 4: buffer entries; power of two, ≥ 2.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_tdata`  in  DATA_WIDTH  element from the extractor.
- `in_tvalid`  in  1  element valid.
- `in_tready`  out  1  buffer can accept.
- `out_tdata`  out  DATA_WIDTH  element at FIFO head.
- `out_tvalid`  out  1  head entry valid.
- `out_tready`  in  1  consumer accepts.
- `out_tlast`  out  1  head entry is element N of its matrix.

## Operation
- Push: `in_tvalid && in_tready`. Pop: `out_tvalid && out_tready`.
- `in_tready = !rst && (count != FIFO_DEPTH)`; no pass-through when full, even if a pop occurs in that cycle.
- Position counters `row` (0..SIZE-1) and `col` (0..row), both reset to 0, advance only on push:
  - `col == row`: `col <= 0`; `row <= (row == SIZE-1) ? 0 : row+1`.
  - otherwise `col <= col+1`.
- Each FIFO entry stores `{last, data}`, `last = (row == SIZE-1) && (col == SIZE-1)` evaluated before the counter update.
- `count` width clog2(FIFO_DEPTH)+1. Push only: +1; pop only: −1; both: unchanged; read/write pointers wrap modulo FIFO_DEPTH.
- `out_tvalid = (count != 0)`. `out_tdata`/`out_tlast` drive head entry when valid, 0 when empty.
- Order strictly FIFO; no reordering, dropping, or duplication.
- Input is trusted to contain only kept elements; no gaps are inferred.

## Timing
- Reset (`rst` high at edge): `count`, pointers, `row`, `col` → 0; `out_tvalid` 0, `out_tdata` 0, `out_tlast` 0; `in_tready` 0 while `rst` is high, 1 from the first cycle after.
- Reset mid-matrix flushes all buffered entries and restarts framing at row 0, col 0; the partial matrix is discarded.
- Latency: element pushed at edge k appears on `out_*` in cycle k+1. Minimum through-latency is 1 cycle.
- Throughput 1 element/cycle with `out_tready` held high and FIFO non-full.
- `out_tvalid` never deasserts without a pop or reset. `out_tdata`/`out_tlast` are stable while `out_tvalid && !out_tready`.
- Full (`count == FIFO_DEPTH`): `in_tready` 0 that cycle; returns to 1 the cycle after a pop.
- Empty plus simultaneous push: entry is visible the next cycle, never the same cycle.
- Counter wrap: after element N, `row`/`col` return to 0 on the same push; back-to-back matrices need no idle cycle.

## Configuration
- `LOWER_TRI_PACK_ROWLAST_EN` defined:
  - Adds output `out_trow_last` (1 bit).
  - Each FIFO entry carries an extra bit set when `col == row` at push.
  - The output drives the head entry's bit, 0 when empty; reset 0.
  - `out_tlast` implies `out_trow_last`.
- Undefined: port and storage bit are absent; all other behaviour is identical.

## Test plan
- Reset, then push 1..10 with `out_tready` = 1 → `out_tdata` 1..10 each one cycle after push; `out_tlast` = 1 only with 10.
- `out_tready` = 0, offer 1..6 → 4 accepted, `in_tready` 0 after 4th push; raise `out_tready` → outputs 1..4, then 5, 6 accepted and output in order.
- Push 20 elements back-to-back, no idle → `out_tlast` on the 10th and 20th outputs only.
- Push 4 elements with `out_tready` = 0, assert `rst` 1 cycle → `out_tvalid` 0, `in_tready` 0 during reset; next 10 pushes → `out_tlast` on the 10th.
- Count = 2, push and pop in the same cycle → count stays 2, `out_tdata` advances to the next entry, new entry enqueued at tail.
- With `LOWER_TRI_PACK_ROWLAST_EN`, push 1..10 → `out_trow_last` = 1 on 1, 3, 6, 10; 0 on all others.
